ternary_neuron_sequencer: RTL and testbench

Time-multiplexed controller for the 2-lane ternary synapse datapath. It holds a bank of N ternary weights and accepts one N-bit binary input vector per transaction. It sequences the vector two synapses per cycle through the lanes and accumulates a signed dot product. It then thresholds the sum and presents a neuron result over a valid/ready handshake. It sits between the pin-level I/O wrapper and the neuron output logic of the fractal net.

---
 rtl/ternary_neuron_sequencer.sv | 126 ++++++++++++
 tb/tb_ternary_neuron_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_sequencer.sv
// Ternary neuron sequencer: streams an N-bit input vector two synapses per cycle through
// a bank of ternary weights, accumulates the signed dot product and thresholds it.
module ternary_neuron_sequencer #(
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned ACC_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_load,
  input  logic [1:0]                  w_data,
  output logic [$clog2(N_INPUTS)-1:0] w_ptr_out,
  input  logic [ACC_W-1:0]            threshold,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_INPUTS-1:0]         in_x,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_sum,
  output logic                        out_fire,
  output logic                        busy
);

  localparam int unsigned PW    = $clog2(N_INPUTS);
  localparam int unsigned PAIRS = N_INPUTS / 2;
  localparam int unsigned KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                state_q;
  logic [PW-1:0]             w_ptr_q;
  logic [1:0]                weight_q [N_INPUTS];
  logic [N_INPUTS-1:0]       x_q;
  logic signed [ACC_W-1:0]   thr_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [KW-1:0]             k_q;
  logic                      out_valid_q;
  logic [ACC_W-1:0]          out_sum_q;
  logic                      out_fire_q;

  logic [1:0]                w0, w1;
  logic                      x0, x1;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      last_pair;

  // bit0 = weight_zero, bit1 = weight_sign; result sign-extended to accumulator width
  function automatic logic signed [ACC_W-1:0] syn(input logic x, input logic [1:0] w);
    if (!x || w[0]) return '0;
    else if (w[1])  return '1;
    else            return ACC_W'(1);
  endfunction

  always_comb begin
    w0 = 2'b01;
    w1 = 2'b01;
    x0 = 1'b0;
    x1 = 1'b0;
    for (int i = 0; i < int'(PAIRS); i++) begin
      if (k_q == KW'(i)) begin
        w0 = weight_q[2*i];
        w1 = weight_q[2*i+1];
        x0 = x_q[2*i];
        x1 = x_q[2*i+1];
      end
    end
    acc_d     = acc_q + syn(x0, w0) + syn(x1, w1);
    last_pair = (k_q == KW'(PAIRS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_ptr_q     <= '0;
      for (int i = 0; i < int'(N_INPUTS); i++) weight_q[i] <= 2'b01;
      x_q         <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_fire_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_load) begin
            weight_q[w_ptr_q] <= w_data;
            w_ptr_q <= (w_ptr_q == PW'(N_INPUTS - 1)) ? '0 : w_ptr_q + 1'b1;
          end
          if (in_valid) begin
            x_q     <= in_x;
            thr_q   <= threshold;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (last_pair) begin
            out_sum_q   <= acc_d;
            out_fire_q  <= (acc_d >= thr_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_fire  = out_fire_q;
  assign w_ptr_out = w_ptr_q;

endmodule

// File: tb/tb_ternary_neuron_sequencer.sv
// Scoreboard bench for ternary_neuron_sequencer: directed vectors push expected results,
// a negedge monitor pops and checks them when out_valid rises.
module tb_ternary_neuron_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_load = 1'b0;
  logic [1:0]  w_data = 2'b01;
  logic [3:0]  w_ptr_out;
  logic [5:0]  threshold = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_sum;
  logic        out_fire;
  logic        busy;

  ternary_neuron_sequencer #(.N_INPUTS(16), .ACC_W(6)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .w_ptr_out(w_ptr_out),
    .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_fire(out_fire),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sum;
    logic       fire;
    int         cyc;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one result per rising out_valid
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_sum"}, 32'(out_sum), 32'(e.sum));
        check({e.name, "_fire"}, 32'(out_fire), 32'(e.fire));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
    prev_valid = out_valid;
  end

  task automatic load(input logic [1:0] d);
    @(negedge clk);
    w_load = 1'b1;
    w_data = d;
    @(posedge clk);
    #1 w_load = 1'b0;
  endtask

  task automatic send(input string name, input logic [15:0] x, input logic [5:0] thr,
                      input logic [5:0] es, input logic ef);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
    in_x      = x;
    threshold = thr;
    in_valid  = 1'b1;
    e.sum  = es;
    e.fire = ef;
    e.cyc  = cyc + 1 + 8;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    threshold = ~thr;
    in_x      = ~x;
  endtask

  // Wait for the result, optionally stall for hold cycles, then consume it.
  task automatic finish(input string name, input int hold, input logic [5:0] es,
                        input logic ef);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({name, "_out_valid_timeout"}, 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        w_load = 1'b1;
        w_data = 2'b00;
      end
      @(negedge clk);
      w_load = 1'b0;
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_sum"}, 32'(out_sum), 32'(es));
      check({name, "_hold_fire"}, 32'(out_fire), 32'(ef));
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({name, "_sum_kept"}, 32'(out_sum), 32'(es));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_fire", 32'(out_fire), 32'd0);
    check("rst_w_ptr", 32'(w_ptr_out), 32'd0);

    // Cleared weights contribute nothing; 0 >= 0 fires
    send("zero_w", 16'hFFFF, 6'd0, 6'd0, 1'b1);
    finish("zero_w", 0, 6'd0, 1'b1);

    for (int i = 0; i < 16; i++) load(2'b00);
    check("ptr_after16", 32'(w_ptr_out), 32'd0);
    send("all_pos", 16'hFFFF, 6'd10, 6'd16, 1'b1);
    finish("all_pos", 0, 6'd16, 1'b1);

    for (int i = 0; i < 16; i++) load(2'b10);
    send("all_neg", 16'hFFFF, 6'd10, 6'b110000, 1'b0);
    finish("all_neg", 0, 6'b110000, 1'b0);

    for (int i = 0; i < 16; i++) load((i % 2) ? 2'b10 : 2'b00);
    send("alt_5555", 16'h5555, 6'd0, 6'd8, 1'b1);
    finish("alt_5555", 0, 6'd8, 1'b1);
    send("alt_aaaa", 16'hAAAA, 6'd0, 6'b111000, 1'b0);
    finish("alt_aaaa", 0, 6'b111000, 1'b0);

    for (int i = 0; i < 17; i++) load((i % 2) ? 2'b10 : 2'b00);
    check("ptr_wrap", 32'(w_ptr_out), 32'd1);

    // Stall in DONE; a w_load during the stall must be ignored
    send("hold", 16'hFFFF, 6'd0, 6'd0, 1'b1);
    finish("hold", 5, 6'd0, 1'b1);
    check("ptr_after_hold", 32'(w_ptr_out), 32'd1);
    // -8 >= -8 boundary; slot 1 still -1 proves the stalled w_load was dropped
    send("after_hold", 16'hAAAA, 6'b111000, 6'b111000, 1'b1);
    finish("after_hold", 0, 6'b111000, 1'b1);

    send("abort", 16'hFFFF, 6'd0, 6'd0, 1'b1);
    repeat (3) @(posedge clk);
    void'(exp_q.pop_back());
    #1 rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_w_ptr", 32'(w_ptr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send("post_abort", 16'hFFFF, 6'd0, 6'd0, 1'b1);
    finish("post_abort", 0, 6'd0, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
